// File: rtl/shift_exec_unit_if.sv
// Handshake bundle between decode, the iterative shift unit and writeback.
// The unit itself takes the slave side; the decode/writeback side takes master.
interface shift_exec_unit_if #(
    parameter int DATA_W  = 16,
    parameter int SHAMT_W = 4,
    parameter int TAG_W   = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_op;
    logic [DATA_W-1:0]  in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [TAG_W-1:0]   in_tag;

    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [TAG_W-1:0]   out_tag;
    logic               out_carry;
    logic               out_zero;
    logic               out_neg;
    logic               out_err;

    modport master (
        output in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_carry, out_zero, out_neg, out_err
    );

    modport slave (
        input  in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_carry, out_zero, out_neg, out_err
    );
endinterface

// File: rtl/shift_exec_unit.sv
// Iterative barrel-free shifter: one shamt bit per cycle (by 1, 2, 4, 8, ...),
// with registered result, flags and tag returned over a valid/ready handshake.
module shift_exec_unit #(
    parameter int DATA_W  = 16,
    parameter int SHAMT_W = 4,
    parameter int TAG_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    shift_exec_unit_if.slave bus
);
    localparam int CNT_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
    localparam logic [SHAMT_W-1:0] ONE  = SHAMT_W'(1);
    localparam logic [CNT_W-1:0]   LAST = CNT_W'(SHAMT_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;
    logic [DATA_W-1:0]  operand_q;
    logic [DATA_W-1:0]  work;
    logic [SHAMT_W-1:0] shamt_q;
    logic [TAG_W-1:0]   tag_q;

    logic               accept;
    logic               illegal;
    logic [SHAMT_W-1:0] step_amt;
    logic [SHAMT_W-1:0] sll_idx;
    logic [SHAMT_W-1:0] srl_idx;
    logic [DATA_W-1:0]  stepped;
    logic [DATA_W-1:0]  next_work;
    logic               final_carry;

    assign bus.in_ready = ~flush & ((state == IDLE) | ((state == DONE) & bus.out_ready));
    assign accept       = bus.in_valid & bus.in_ready;
    assign illegal      = (op_q > 3'd4);

    // One stage of the shift ladder plus the carry taken from the latched operand
    // (linear shifts) or from the final result (rotates).
    always_comb begin
        step_amt = ONE << cnt;
        stepped  = work;
        case (op_q)
            3'd0:    stepped = work << step_amt;
            3'd1:    stepped = work >> step_amt;
            3'd2:    stepped = $signed(work) >>> step_amt;
            3'd3:    stepped = (work << step_amt) | (work >> (DATA_W - int'(step_amt)));
            3'd4:    stepped = (work >> step_amt) | (work << (DATA_W - int'(step_amt)));
            default: stepped = work;
        endcase
        next_work = shamt_q[cnt] ? stepped : work;

        sll_idx     = ~shamt_q + ONE;
        srl_idx     = shamt_q - ONE;
        final_carry = 1'b0;
        if (shamt_q != '0) begin
            case (op_q)
                3'd0:       final_carry = operand_q[sll_idx];
                3'd1, 3'd2: final_carry = operand_q[srl_idx];
                3'd3:       final_carry = next_work[0];
                3'd4:       final_carry = next_work[DATA_W-1];
                default:    final_carry = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            op_q          <= '0;
            operand_q     <= '0;
            work          <= '0;
            shamt_q       <= '0;
            tag_q         <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_tag   <= '0;
            bus.out_carry <= 1'b0;
            bus.out_zero  <= 1'b0;
            bus.out_neg   <= 1'b0;
            bus.out_err   <= 1'b0;
        end else if (flush) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (state == DONE && bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                    if (accept) begin
                        op_q      <= bus.in_op;
                        operand_q <= bus.in_data;
                        work      <= bus.in_data;
                        shamt_q   <= bus.in_shamt;
                        tag_q     <= bus.in_tag;
                        cnt       <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= next_work;
                    if (cnt == LAST) begin
                        cnt           <= '0;
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= next_work;
                        bus.out_tag   <= tag_q;
                        bus.out_carry <= final_carry;
                        bus.out_zero  <= (next_work == '0);
                        bus.out_neg   <= next_work[DATA_W-1];
                        bus.out_err   <= illegal;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_exec_unit.sv
// Directed bench for shift_exec_unit: hand-computed results, latency, hold,
// back-to-back issue, flush and asynchronous reset.
module tb_shift_exec_unit;
    logic clk;
    logic rst;
    logic flush;
    int   check_count;
    int   error_count;

    shift_exec_unit_if #(.DATA_W(16), .SHAMT_W(4), .TAG_W(3)) bus ();

    shift_exec_unit #(.DATA_W(16), .SHAMT_W(4), .TAG_W(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a micro-op and hold it until the unit takes it on a clock edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] data,
                                 input logic [3:0] shamt, input logic [2:0] tag);
        bit done;
        done         = 1'b0;
        bus.in_op    = op;
        bus.in_data  = data;
        bus.in_shamt = shamt;
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
        #0;
        for (int k = 0; k < 40; k++) begin
            if (bus.in_ready) begin
                step();
                done = 1'b1;
                break;
            end
            step();
        end
        bus.in_valid = 1'b0;
        if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic checkResult(input string name, input logic [15:0] exp_data, input logic [2:0] exp_tag,
                               input logic exp_carry, input logic exp_err);
        checkOutput({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        checkOutput({name, "_data"},  32'(bus.out_data),  32'(exp_data));
        checkOutput({name, "_tag"},   32'(bus.out_tag),   32'(exp_tag));
        checkOutput({name, "_carry"}, 32'(bus.out_carry), 32'(exp_carry));
        checkOutput({name, "_zero"},  32'(bus.out_zero),  32'(exp_data == 16'h0000));
        checkOutput({name, "_neg"},   32'(bus.out_neg),   32'(exp_data[15]));
        checkOutput({name, "_err"},   32'(bus.out_err),   32'(exp_err));
    endtask

    // Issue, check that the result appears exactly four edges after the accept edge, retire.
    task automatic runOp(input string name, input logic [2:0] op, input logic [15:0] data,
                         input logic [3:0] shamt, input logic [2:0] tag,
                         input logic [15:0] exp_data, input logic exp_carry, input logic exp_err);
        applyStimulus(op, data, shamt, tag);
        repeat (3) step();
        checkOutput({name, "_early"}, 32'(bus.out_valid), 32'd0);
        step();
        checkResult(name, exp_data, tag, exp_carry, exp_err);
        step();
        checkOutput({name, "_retired"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        bit seen;
        check_count   = 0;
        error_count   = 0;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        repeat (2) step();
        checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_data",  32'(bus.out_data),  32'd0);
        checkOutput("rst_tag",   32'(bus.out_tag),   32'd0);
        checkOutput("rst_flags", 32'({bus.out_carry, bus.out_zero, bus.out_neg, bus.out_err}), 32'd0);
        rst = 1'b0;
        step();
        checkOutput("idle_ready", 32'(bus.in_ready), 32'd1);

        runOp("sra4",    3'd2, 16'h8001, 4'd4,  3'd5, 16'hF800, 1'b0, 1'b0);
        runOp("srl15",   3'd1, 16'h8001, 4'd15, 3'd1, 16'h0001, 1'b0, 1'b0);
        runOp("sll1",    3'd0, 16'h8001, 4'd1,  3'd2, 16'h0002, 1'b1, 1'b0);
        runOp("ror1",    3'd4, 16'h0001, 4'd1,  3'd3, 16'h8000, 1'b1, 1'b0);
        runOp("rol4",    3'd3, 16'hF000, 4'd4,  3'd4, 16'h000F, 1'b1, 1'b0);
        runOp("zero0",   3'd3, 16'h0000, 4'd0,  3'd6, 16'h0000, 1'b0, 1'b0);
        runOp("illegal", 3'd6, 16'h1234, 4'd3,  3'd7, 16'h1234, 1'b0, 1'b1);
        runOp("sll5",    3'd0, 16'h0C01, 4'd5,  3'd0, 16'h8020, 1'b1, 1'b0);

        // Result held while writeback stalls, then back-to-back issue.
        bus.out_ready = 1'b0;
        applyStimulus(3'd0, 16'h0003, 4'd2, 3'd1);
        repeat (4) step();
        checkResult("hold0", 16'h000C, 3'd1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("hold_data",  32'(bus.out_data),  32'h000C);
            checkOutput("hold_ready", 32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("b2b_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(3'd1, 16'h00F0, 4'd4, 3'd2);
        checkOutput("b2b_retired", 32'(bus.out_valid), 32'd0);
        repeat (4) step();
        checkResult("b2b1", 16'h000F, 3'd2, 1'b0, 1'b0);
        applyStimulus(3'd3, 16'h8000, 4'd1, 3'd7);
        checkOutput("b2b_retired2", 32'(bus.out_valid), 32'd0);
        repeat (4) step();
        checkResult("b2b2", 16'h0001, 3'd7, 1'b1, 1'b0);
        step();

        // Flush two cycles into SHIFT discards the op.
        applyStimulus(3'd0, 16'h0001, 4'd15, 3'd3);
        repeat (2) step();
        flush = 1'b1;
        #1;
        checkOutput("flush_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        flush = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (bus.out_valid) seen = 1'b1;
            step();
        end
        checkOutput("flush_no_valid", 32'(seen), 32'd0);
        checkOutput("flush_idle_ready", 32'(bus.in_ready), 32'd1);

        // Async reset between clock edges clears the held 0x0001/tag 7 result at once.
        applyStimulus(3'd2, 16'h8000, 4'd5, 3'd4);
        repeat (2) step();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("arst_data",  32'(bus.out_data),  32'd0);
        checkOutput("arst_tag",   32'(bus.out_tag),   32'd0);
        checkOutput("arst_carry", 32'(bus.out_carry), 32'd0);
        step();
        rst = 1'b0;
        step();
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus.out_valid) seen = 1'b1;
            step();
        end
        checkOutput("arst_op_lost", 32'(seen), 32'd0);
        runOp("post_rst", 3'd4, 16'h0003, 4'd1, 3'd5, 16'h8001, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end
endmodule
